// File: rtl/cpu_pkg.sv
// cpu_pkg: register control codes, opcodes, ALU selects and sequencer states shared across the CPU
package cpu_pkg;
  localparam logic [2:0] HOLD   = 3'b000;
  localparam logic [2:0] LOAD   = 3'b001;
  localparam logic [2:0] SHIFTR = 3'b010;
  localparam logic [2:0] SHIFTL = 3'b011;
  localparam logic [2:0] RESET  = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LDX = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;
  localparam logic [1:0] ULA_ADD  = 2'b00;
  localparam logic [1:0] ULA_SUB  = 2'b01;
  localparam logic [1:0] ULA_PASS = 2'b10;
  typedef enum logic [1:0] {IDLE, EXEC, WB, SHIFT} state_t;
endpackage

// File: rtl/micro_sequencer.sv
// micro_sequencer: expands one accepted instruction into registered per-cycle X/Y/Z control codes
module micro_sequencer
  import cpu_pkg::*;
#(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [CNT_W+2:0]     instr,
  output logic [CODE_W-1:0]    Tx,
  output logic [CODE_W-1:0]    Ty,
  output logic [CODE_W-1:0]    Tz,
  output logic [1:0]           ula_op,
  output logic                 done,
  output logic                 illegal
);
  state_t           state;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       opc;
  logic [CNT_W-1:0] n;
  assign opc = instr[CNT_W+2:CNT_W];
  assign n = instr[CNT_W-1:0];
  assign instr_ready = state == IDLE;
  // Sequencer FSM: outputs default to HOLD every cycle and are overridden only in the listed control cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= OP_CLR;
      cnt <= '0;
      Tx <= HOLD;
      Ty <= HOLD;
      Tz <= HOLD;
      ula_op <= ULA_ADD;
      done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      Tx <= HOLD;
      Ty <= HOLD;
      Tz <= HOLD;
      ula_op <= ULA_ADD;
      done <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          op <= opc;
          cnt <= n;
          state <= EXEC;
          case (opc)
            OP_CLR: begin
              Tx <= RESET;
              Ty <= RESET;
              Tz <= RESET;
              done <= 1'b1;
            end
            OP_LDX: begin
              Tx <= LOAD;
              done <= 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Ty <= LOAD;
              ula_op <= opc == OP_SUB ? ULA_SUB : ULA_ADD;
            end
            OP_SHR, OP_SHL: if (n != '0) begin
              state <= SHIFT;
              Tz <= opc == OP_SHL ? SHIFTL : SHIFTR;
              done <= n == CNT_W'(1);
            end else begin
              done <= 1'b1;
            end
            OP_MOV: begin
              Tz <= LOAD;
              ula_op <= ULA_PASS;
              done <= 1'b1;
            end
            default: begin
              illegal <= 1'b1;
              done <= 1'b1;
            end
          endcase
        end
        EXEC: if (op == OP_ADD || op == OP_SUB) begin
          state <= WB;
          Tz <= LOAD;
          ula_op <= op == OP_SUB ? ULA_SUB : ULA_ADD;
          done <= 1'b1;
        end else begin
          state <= IDLE;
        end
        WB: state <= IDLE;
        SHIFT: if (cnt == CNT_W'(1)) begin
          state <= IDLE;
          cnt <= '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
          Tz <= op == OP_SHL ? SHIFTL : SHIFTR;
          done <= cnt == CNT_W'(2);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Control stage directly upstream of the X/Y/Z register file of the 4-bit CPU. It accepts one instruction at a time over a valid/ready handshake. It expands each instruction into a cycle-by-cycle sequence of 3-bit register control codes (Tx, Ty, Tz) and an ALU select. Every cycle it issues no explicit action, it drives HOLD to all registers.

Parameters:
CODE_W, 3, width of each register control code
CNT_W, 2, width of the shift-count field (max 3 shifts per instruction)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr_ready  output  1  sequencer can accept an instruction this cycle
instr  input  5  [4:2] opcode, [1:0] shift count n
Tx  output  CODE_W  control code to register X
Ty  output  CODE_W  control code to register Y
Tz  output  CODE_W  control code to register Z
ula_op  output  2  ALU select: 00 ADD, 01 SUB, 10 PASS
done  output  1  one-cycle pulse in the last control cycle of an instruction
illegal  output  1  one-cycle pulse when opcode 111 is accepted

Behaviour:
- Control codes: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100. Codes 101–111 are never driven.
- Reset (rst=1 at clk edge):
  - state=IDLE, Tx=Ty=Tz=HOLD, ula_op=00, done=0, illegal=0, counter=0.
  - instr_ready=1 in the cycle after reset.
  - Reset mid-instruction aborts it: no further codes are issued and no done pulse occurs.
- Handshake:
  - Accept only when instr_valid && instr_ready.
  - instr_ready=1 only in IDLE. instr is latched on accept.
  - instr changes while instr_ready=0 are ignored.
- Timing: all outputs are registered. The first control cycle is the cycle after accept. Back-to-back instructions are separated by at least one IDLE cycle.
- States: IDLE, EXEC, WB, SHIFT.
- Per-opcode sequences (C1 = first cycle after accept):
  - 000 CLR: C1 Tx=Ty=Tz=RESET, done=1. Back to IDLE.
  - 001 LDX: C1 Tx=LOAD, done=1.
  - 010 ADD:
    - C1 (EXEC): Ty=LOAD, ula_op=00.
    - C2 (WB): Tz=LOAD, ula_op=00, done=1.
  - 011 SUB: same as ADD with ula_op=01 in both cycles.
  - 100 SHR:
    - n>0: SHIFT state, Tz=SHIFTR for exactly n consecutive cycles. done=1 in the nth cycle.
    - n=0: one cycle with all codes HOLD and done=1.
  - 101 SHL: same as SHR with SHIFTL.
  - 110 MOV: C1 Tz=LOAD, ula_op=10, done=1.
  - 111 reserved: C1 all HOLD, illegal=1, done=1.
- Counter:
  - Loaded with n on accept, decremented each SHIFT cycle.
  - Leave SHIFT when counter==1 at the clock edge. No wrap-around.
- Outside the listed cycles: all codes HOLD, ula_op=00, done=0.
- Unused count field: n is ignored for non-shift opcodes.
- instr_valid held high across an instruction: the next instruction is taken on the IDLE cycle after done. It is never dropped and never double-accepted.

Decomposition:
- Shared package cpu_pkg:
  - register control-code constants (HOLD, LOAD, SHIFTR, SHIFTL, RESET)
  - opcode constants
  - ula_op constants
  - state enum
- The same code constants must be used by the register modules.
- No sub-module is needed: the shift counter is a few lines inside the FSM.

Test Plan:
- Reset: assert rst 2 cycles, then release → Tx=Ty=Tz=000, done=0, instr_ready=1 on the first cycle after release.
- ADD: instr=01000 accepted at cycle t → t+1: Ty=001, ula_op=00; t+2: Tz=001, done=1; t+3: instr_ready=1, all codes 000.
- SHL with n=3: instr=10111 → Tz=011 for 3 consecutive cycles, done only in the third; SHR with n=0 (10000) → one cycle all 000 with done=1.
- Back-to-back: instr_valid held high with LDX then CLR → Tx=001 with done, one IDLE cycle, then Tx=Ty=Tz=100 with done; exactly two accepts.
- Reset mid-shift: SHR n=3, rst asserted during the second SHIFTR cycle → next cycle all 000, no done, instr_ready=1 after release.
- Reserved opcode: instr=11100 → one cycle all 000 with illegal=1 and done=1; register codes never take values 101–111 in any test.
